// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: loads win, ALU writebacks queue in an in-order FIFO,
// with a WAW guard on same-register writes, a starvation bound, and pending-write queries.
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       mem_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_a3,
    output logic [DATA_W-1:0]          rf_wd,
    input  logic [ADDR_W-1:0]          q_addr1,
    input  logic [ADDR_W-1:0]          q_addr2,
    output logic                       q_pend1,
    output logic                       q_pend2,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 2);

    logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             ent_vld;
    logic [PW-1:0]                wptr, rptr;
    logic [CW-1:0]                count;
    logic [SW-1:0]                starve_cnt;

    logic [DEPTH-1:0] hit_mem, hit_q1, hit_q2;
    logic             conflict, force_head, mem_wr, push, pop, nonempty;

    // Per-entry address compare against the live FIFO contents
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign hit_mem[i] = ent_vld[i] && (rd_q[i] == mem_rd);
        assign hit_q1[i]  = ent_vld[i] && (rd_q[i] == q_addr1);
        assign hit_q2[i]  = ent_vld[i] && (rd_q[i] == q_addr2);
    end

    assign nonempty   = (count != '0);
    assign alu_ready  = (count < CW'(DEPTH));
    assign conflict   = mem_valid && (mem_rd != '0) && (|hit_mem);
    assign force_head = nonempty && (starve_cnt >= SW'(STARVE_LIMIT));
    assign mem_ready  = mem_valid && !conflict && !force_head;
    assign mem_wr     = mem_ready && (mem_rd != '0);
    // A granted x0 load leaves the port free, so the head can still drain.
    assign pop        = !mem_wr && nonempty;
    assign push       = alu_valid && alu_ready && (alu_rd != '0);
    assign fifo_count = count;

    assign q_pend1 = (q_addr1 != '0) && ((|hit_q1) || (rf_we && rf_a3 == q_addr1));
    assign q_pend2 = (q_addr2 != '0) && ((|hit_q2) || (rf_we && rf_a3 == q_addr2));

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr]   <= alu_rd;
            data_q[wptr] <= alu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld    <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (pop) begin
                ent_vld[rptr] <= 1'b0;
                rptr          <= rptr + PW'(1);
            end
            if (push) begin
                ent_vld[wptr] <= 1'b1;
                wptr          <= wptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (!nonempty || pop)
                starve_cnt <= '0;
            else if (starve_cnt < SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else if (mem_wr) begin
            rf_we <= 1'b1;
            rf_a3 <= mem_rd;
            rf_wd <= mem_data;
        end else if (pop) begin
            rf_we <= 1'b1;
            rf_a3 <= rd_q[rptr];
            rf_wd <= data_q[rptr];
        end else begin
            rf_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: hand-computed expectations checked by immediate assertions.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd, q_addr1, q_addr2;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rf_we, q_pend1, q_pend2;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks happen 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mem_valid = v; mem_rd = rd; mem_data = d;
    endtask

    initial begin
        rst = 1'b1;
        alu(0, 0, 0); mem(0, 0, 0);
        q_addr1 = 5'd0; q_addr2 = 5'd0;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_a3", rf_a3, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_aready", alu_ready, 1);
        chk("rst_mready", mem_ready, 0);
        chk("rst_pend", q_pend1, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // ALU only: accepted in cycle t, written in t+2
        alu(1, 5, 32'h11); q_addr1 = 5'd5;
        #1 chk("alu_ready0", alu_ready, 1);
        chk("alu_pend_t", q_pend1, 0);
        tick(); alu(0, 0, 0);
        #1 chk("alu_cnt_t1", fifo_count, 1);
        chk("alu_pend_t1", q_pend1, 1);
        chk("alu_we_t1", rf_we, 0);
        tick();
        #1 chk("alu_we_t2", rf_we, 1);
        chk("alu_a3_t2", rf_a3, 5);
        chk("alu_wd_t2", rf_wd, 32'h11);
        chk("alu_pend_t2", q_pend1, 1);
        chk("alu_cnt_t2", fifo_count, 0);
        tick();
        #1 chk("alu_we_t3", rf_we, 0);
        chk("alu_pend_t3", q_pend1, 0);

        // Priority: three loads back to back while two ALU results queue
        mem(1, 7, 32'h70); alu(1, 1, 32'h1);
        #1 chk("pri_mready0", mem_ready, 1);
        tick(); mem(1, 8, 32'h80); alu(1, 2, 32'h2);
        #1 chk("pri_mready1", mem_ready, 1);
        chk("pri_a3_7", rf_a3, 7);
        chk("pri_wd_7", rf_wd, 32'h70);
        tick(); mem(1, 9, 32'h90); alu(0, 0, 0);
        #1 chk("pri_a3_8", rf_a3, 8);
        chk("pri_cnt2", fifo_count, 2);
        chk("pri_mready2", mem_ready, 1);
        tick(); mem(0, 0, 0);
        #1 chk("pri_a3_9", rf_a3, 9);
        chk("pri_we_9", rf_we, 1);
        tick();
        #1 chk("pri_a3_1", rf_a3, 1);
        chk("pri_wd_1", rf_wd, 32'h1);
        tick();
        #1 chk("pri_a3_2", rf_a3, 2);
        chk("pri_wd_2", rf_wd, 32'h2);
        chk("pri_cnt0", fifo_count, 0);
        tick();
        #1 chk("pri_idle", rf_we, 0);

        // WAW: queued ALU rd4 must land before the load to rd4
        alu(1, 4, 32'hA);
        tick(); alu(0, 0, 0); mem(1, 4, 32'hB);
        #1 chk("waw_block", mem_ready, 0);
        tick();
        #1 chk("waw_first", rf_wd, 32'hA);
        chk("waw_a3", rf_a3, 4);
        chk("waw_grant", mem_ready, 1);
        tick(); mem(0, 0, 0);
        #1 chk("waw_second", rf_wd, 32'hB);
        chk("waw_we", rf_we, 1);

        // Same rd together: load is older, ALU value lands last
        alu(1, 6, 32'h60); mem(1, 6, 32'h61);
        #1 chk("same_mready", mem_ready, 1);
        tick(); alu(0, 0, 0); mem(0, 0, 0);
        #1 chk("same_first", rf_wd, 32'h61);
        chk("same_cnt", fifo_count, 1);
        tick();
        #1 chk("same_second", rf_wd, 32'h60);
        tick();

        // Starvation: head loses 3 cycles, then is forced through
        alu(1, 3, 32'h33); mem(1, 10, 32'hA0);
        #1 chk("stv_g0", mem_ready, 1);
        tick(); alu(0, 0, 0); mem(1, 11, 32'hB0);
        #1 chk("stv_g1", mem_ready, 1);
        tick(); mem(1, 12, 32'hC0);
        #1 chk("stv_g2", mem_ready, 1);
        tick(); mem(1, 13, 32'hD0);
        #1 chk("stv_g3", mem_ready, 1);
        tick(); mem(1, 14, 32'hE0);
        #1 chk("stv_force", mem_ready, 0);
        tick();
        #1 chk("stv_a3", rf_a3, 3);
        chk("stv_wd", rf_wd, 32'h33);
        chk("stv_regrant", mem_ready, 1);
        tick(); mem(0, 0, 0);
        #1 chk("stv_after", rf_a3, 14);
        tick(); tick();

        // Fill FIFO while loads hold the port, then reset mid-stream
        alu(1, 16, 32'h16); mem(1, 20, 32'h20);
        tick(); alu(1, 17, 32'h17); mem(1, 21, 32'h21);
        tick(); alu(1, 18, 32'h18); mem(1, 22, 32'h22);
        tick(); alu(1, 19, 32'h19); mem(1, 23, 32'h23);
        tick(); alu(0, 0, 0); mem(0, 0, 0); q_addr1 = 5'd19;
        #1 chk("full_cnt", fifo_count, 4);
        chk("full_aready", alu_ready, 0);
        chk("full_pend", q_pend1, 1);
        chk("full_we", rf_we, 1);
        rst = 1'b1;
        #1 chk("mrst_we", rf_we, 0);
        chk("mrst_cnt", fifo_count, 0);
        chk("mrst_aready", alu_ready, 1);
        chk("mrst_pend", q_pend1, 0);
        tick(); rst = 1'b0;
        tick();

        // x0 handling on both paths
        alu(1, 0, 32'hFF); mem(1, 0, 32'hEE); q_addr2 = 5'd0;
        #1 chk("x0_aready", alu_ready, 1);
        chk("x0_mready", mem_ready, 1);
        chk("x0_pend", q_pend2, 0);
        tick(); alu(0, 0, 0); mem(0, 0, 0);
        #1 chk("x0_we", rf_we, 0);
        chk("x0_cnt", fifo_count, 0);
        alu(1, 25, 32'h25);
        tick(); alu(0, 0, 0); mem(1, 0, 32'hEE);
        #1 chk("x0pop_mready", mem_ready, 1);
        tick(); mem(0, 0, 0);
        #1 chk("x0pop_a3", rf_a3, 25);
        chk("x0pop_we", rf_we, 1);
        chk("x0pop_cnt", fifo_count, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (we/addr/data) between two writeback sources: the ALU path and the load/memory path.
- The load path has priority. ALU writes are held in a small in-order FIFO, so an ALU result is never lost while a load is writing.
- A WAW guard keeps same-register writes in program order.
- A starvation counter bounds how long the FIFO can wait.
- Pending-write query ports let the hazard unit stall reads of registers whose writes have not yet landed.

Parameters:
- DEPTH, 4, ALU write FIFO entries (power of 2, ≥2)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may lose to the load path before it is forced through

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  FIFO can accept; equals (count < DEPTH)
- mem_valid  in  1  load writeback request
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request granted this cycle
- rf_we  out  1  register file write enable (registered)
- rf_a3  out  ADDR_W  register file write address (registered)
- rf_wd  out  DATA_W  register file write data (registered)
- q_addr1, q_addr2  in  ADDR_W  hazard query addresses
- q_pend1, q_pend2  out  1  a write to the queried register is pending
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, rst=1):
  - rf_we=0, rf_a3=0, rf_wd=0.
  - FIFO empty (pointers 0, count 0).
  - Starvation counter = 0.
  - Combinational outputs follow from this state: alu_ready=1, mem_ready=0, q_pend*=0.
- Reset mid-operation: all queued ALU writes are discarded, and any write in the output stage is dropped (rf_we forced 0 immediately).
- ALU handshake:
  - The request is accepted when alu_valid && alu_ready.
  - alu_ready uses the start-of-cycle count only. There is no pass-through when full, even if a pop happens in the same cycle.
  - An accepted write with alu_rd==0 completes the handshake but is not stored.
- Conflict: conflict = mem_valid && mem_rd!=0 && mem_rd matches any valid FIFO entry.
- Grant logic, evaluated each cycle on start-of-cycle state:
  - force = (count>0) && (starve_cnt ≥ STARVE_LIMIT).
  - mem_ready = mem_valid && !conflict && !force.
  - If mem_ready and mem_rd!=0: next rf_we=1, rf_a3=mem_rd, rf_wd=mem_data.
  - Else if count>0: pop the FIFO head; next rf_we=1 with the head's rd/data.
  - Otherwise next rf_we=0. rf_a3/rf_wd hold their previous values.
  - A load to x0 is granted and dropped; the FIFO head may pop in that same cycle.
- Starvation counter:
  - Increments when count>0 and the head did not pop.
  - Cleared on any pop, or when count==0.
  - Saturates at STARVE_LIMIT.
- Latency:
  - A granted request appears on rf_* the next cycle.
  - An ALU entry reaches rf_* no earlier than 2 cycles after acceptance (enqueue, then pop).
- Simultaneous events:
  - Enqueue and pop in the same cycle leave count unchanged.
  - When ALU and load arrive together with the same rd, the load is treated as older: it is granted first and the ALU entry is queued behind it.
  - When the conflict check and an incoming ALU enqueue happen in the same cycle, only start-of-cycle FIFO contents are checked.
- Pending queries (combinational):
  - q_pendN=1 if q_addrN!=0 and q_addrN matches any valid FIFO entry, or (rf_we && rf_a3==q_addrN).
  - Queries to x0 always return 0.
- FIFO pointers wrap modulo DEPTH.
- Overflow is impossible by construction. Underflow never occurs because a pop requires count>0.

Test Plan:
- Reset then idle: assert rst mid-stream with 2 entries queued → rf_we=0 immediately, fifo_count=0, alu_ready=1, q_pend1=0 for a queued rd.
- ALU only: alu rd=5 data=0x11 accepted at cycle t → rf_we=1, rf_a3=5, rf_wd=0x11 at t+2; q_pend1 (q_addr1=5) high from t+1 through the cycle rf_we is shown.
- Priority/buffer: hold mem_valid for 3 cycles (rd 7, 8, 9) while ALU sends rd 1, 2 → loads written in cycles t+1..t+3; ALU entries follow in order rd 1 then rd 2; no write is lost.
- WAW guard: ALU rd=4 data=0xA queued, then mem rd=4 data=0xB → mem_ready=0 until the rd=4 FIFO entry pops; final write order is 0xA then 0xB.
- Starvation: continuous mem_valid with distinct rds and 1 queued ALU entry, STARVE_LIMIT=3 → after 3 lost cycles, mem_ready=0 for one cycle and the ALU entry is written.
- Full and x0 handling: fill 4 entries → alu_ready=0 with fifo_count=4; an ALU write to rd=0 and a mem write to rd=0 both handshake, produce no rf_we, and do not change fifo_count.
